// File: rtl/fetch_unit_du.sv
// MIPS IF stage with debug-unit program load, run/step/halt control,
// HALT-word detection and out-of-range fetch fault.
module fetch_unit_du #(
  parameter int unsigned          NB_BITS   = 32,
  parameter int unsigned          MEM_DEPTH = 64,
  parameter logic [NB_BITS-1:0]   RESET_PC  = '0,
  parameter logic [NB_BITS-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_brq_addr,
  input  logic [NB_BITS-1:0] i_jmp_addr,
  input  logic               i_ctr_beq,
  input  logic               i_ctr_jmp,
  input  logic               i_ctr_flush,
  input  logic               i_pc_we,
  input  logic               i_if_id_we,
  input  logic [1:0]         i_du_cmd,
  input  logic               i_du_step,
  input  logic               i_du_wr_en,
  input  logic [NB_BITS-1:0] i_du_addr,
  input  logic [NB_BITS-1:0] i_du_data,
  output logic [NB_BITS-1:0] o_if_id_pc,
  output logic [NB_BITS-1:0] o_if_id_instr,
  output logic [NB_BITS-1:0] o_pc,
  output logic [1:0]         o_state,
  output logic               o_halted,
  output logic               o_fault
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_LOAD = 2'b11
  } cmd_t;

  logic [NB_BITS-1:0] r_mem [MEM_DEPTH];
  state_t             r_state;
  logic [NB_BITS-1:0] r_pc;
  logic [NB_BITS-1:0] r_if_id_pc;
  logic [NB_BITS-1:0] r_if_id_instr;
  logic               r_fault;

  logic [AW-1:0]      w_pc_idx;
  logic [AW-1:0]      w_du_idx;
  logic               w_pc_in_range;
  logic               w_du_in_range;
  logic [NB_BITS-1:0] w_fetch_word;
  logic [NB_BITS-1:0] w_pc_plus4;
  logic [NB_BITS-1:0] w_pc_next;
  logic               w_adv;
  logic               w_stop;
  cmd_t               w_cmd;

  always_comb begin
    w_cmd         = cmd_t'(i_du_cmd);
    w_pc_idx      = r_pc[AW+1:2];
    w_du_idx      = i_du_addr[AW+1:2];
    w_pc_in_range = (r_pc >> (AW + 2)) == '0;
    w_du_in_range = (i_du_addr >> (AW + 2)) == '0;
    // Out-of-range fetches yield a zero word so a stalled PC past the end stays defined
    w_fetch_word  = w_pc_in_range ? r_mem[w_pc_idx] : '0;
    w_pc_plus4    = r_pc + NB_BITS'(4);
    w_pc_next     = i_ctr_jmp ? i_jmp_addr : (i_ctr_beq ? i_brq_addr : w_pc_plus4);
    w_adv         = (r_state == S_RUN) || ((r_state == S_STEP) && i_du_step);
    w_stop        = w_adv && i_pc_we && (!w_pc_in_range || (w_fetch_word == HALT_WORD));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == S_LOAD) && i_du_wr_en && w_du_in_range)
      r_mem[w_du_idx] <= i_du_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_LOAD;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
      r_fault       <= 1'b0;
    end else if (w_cmd == CMD_LOAD) begin
      r_state       <= S_LOAD;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_instr <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_cmd == CMD_RUN) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
          end else if (w_cmd == CMD_STEP) begin
            r_state <= S_STEP;
            r_pc    <= RESET_PC;
          end
        end
        S_RUN:   if (w_cmd == CMD_STEP) r_state <= S_STEP;
        S_STEP:  if (w_cmd == CMD_RUN)  r_state <= S_RUN;
        default: ;
      endcase
      // A halt or fault wins over any mode change requested in the same cycle
      if (w_stop) begin
        r_state       <= S_HALTED;
        r_if_id_instr <= '0;
        r_if_id_pc    <= w_pc_plus4;
        if (!w_pc_in_range) r_fault <= 1'b1;
      end else if (w_adv) begin
        if (i_pc_we) r_pc <= w_pc_next;
        if (i_if_id_we) begin
          r_if_id_instr <= i_ctr_flush ? '0 : w_fetch_word;
          r_if_id_pc    <= w_pc_plus4;
        end
      end
    end
  end

  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_pc          = r_pc;
  assign o_state       = r_state;
  assign o_halted      = (r_state == S_HALTED);
  assign o_fault       = r_fault;

endmodule

// File: doc/fetch_unit_du.md
Name: fetch_unit_du

Overview:
- Parametrised IF stage for the MIPS pipeline, next generation of the current fetch block.
- Adds a debug-unit (DU) program-load port, run/step/halt control FSM, configurable memory depth and reset PC, HALT-word detection and out-of-range fetch fault.
- Sits between DU/hazard/control logic and the IF/ID boundary; drives IF/ID PC and instruction registers.

Parameters:
- NB_BITS, 32, data/address width.
- MEM_DEPTH, 64, instruction memory depth in words (power of 2, >= 2).
- RESET_PC, 0, PC loaded on reset and on every LOAD→RUN/STEP entry; word aligned.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_brq_addr  in  NB_BITS  branch target.
- i_jmp_addr  in  NB_BITS  jump target.
- i_ctr_beq  in  1  take branch.
- i_ctr_jmp  in  1  take jump (priority over beq).
- i_ctr_flush  in  1  load NOP into IF/ID instead of memory word.
- i_pc_we  in  1  PC write enable (hazard stall when 0).
- i_if_id_we  in  1  IF/ID write enable.
- i_du_cmd  in  2  00 none, 01 run, 10 step mode, 11 go to LOAD.
- i_du_step  in  1  single-cycle pulse: advance one fetch in STEP.
- i_du_wr_en  in  1  instruction memory write strobe.
- i_du_addr  in  NB_BITS  byte address for DU write.
- i_du_data  in  NB_BITS  instruction word to write.
- o_if_id_pc  out  NB_BITS  registered PC+4 of fetched instruction.
- o_if_id_instr  out  NB_BITS  registered instruction.
- o_pc  out  NB_BITS  current PC.
- o_state  out  2  00 LOAD, 01 RUN, 10 STEP, 11 HALTED.
- o_halted  out  1  state==HALTED.
- o_fault  out  1  sticky: halt caused by out-of-range fetch.

Behaviour:
- Reset: state=LOAD, pc=RESET_PC, o_if_id_pc=0, o_if_id_instr=0 (NOP), o_fault=0. Memory contents not cleared.
- Memory: MEM_DEPTH x NB_BITS, combinational read at index pc[log2(MEM_DEPTH)+1:2]; synchronous write.
- DU write: only in LOAD with i_du_wr_en=1 and i_du_addr>>2 < MEM_DEPTH; index i_du_addr>>2. Ignored in other states or when out of range.
- FSM:
  - LOAD: cmd 01→RUN, cmd 10→STEP; pc:=RESET_PC on exit.
  - RUN: cmd 10→STEP.
  - STEP: cmd 01→RUN.
  - HALTED: stays until cmd 11.
  - cmd 11 from any state → LOAD next cycle; pc:=RESET_PC; IF/ID:=NOP, if_id_pc:=0.
- adv = (RUN) or (STEP and i_du_step). No PC/IF/ID update outside adv.
- fetch_word = mem[index] if pc>>2 < MEM_DEPTH, else out-of-range.
- On adv and i_pc_we (normal fetch):
  - Halt: fetch_word==HALT_WORD → state:=HALTED, pc held, IF/ID:=NOP, if_id_pc:=pc+4.
  - Out of range: state:=HALTED, o_fault:=1, pc held, IF/ID:=NOP.
  - Otherwise next pc = jmp ? i_jmp_addr : beq ? i_brq_addr : pc+4 (mod 2^NB_BITS).
- IF/ID update on adv and i_if_id_we:
  - i_ctr_flush=1 → instr:=0.
  - Otherwise → instr:=fetch_word.
  - if_id_pc:=pc+4.
- i_if_id_we=0 holds IF/ID.
- Halt/fault check overrides jmp/beq/flush.
- i_pc_we=0 with adv: pc held, no halt evaluation.
- cmd 11 has priority over halt/fault detection in the same cycle.
- i_rst has priority over all.
- Latency: instruction at pc appears on o_if_id_instr one clock after adv edge.
- i_du_step held high counts one step per cycle; no edge detection in this block.

Test Plan:
- Load: writes 0x20010005 @0x0, 0x20020003 @0x4, HALT @0x8 in LOAD, then cmd 01 → IF/ID shows (4,0x20010005), (8,0x20020003), then NOP, state=11, o_pc=0x8, o_fault=0.
- Branch/jump: RUN at pc=0x4 with beq=1, brq=0x10 → next pc=0x10. Same cycle jmp=1, jmp_addr=0x20 → pc=0x20 (jump wins).
- Stall/flush: i_pc_we=0, i_if_id_we=0 for 3 cycles → pc and IF/ID frozen. Flush=1 with if_id_we=1 → instr=0, if_id_pc=pc+4.
- Step: cmd 10, three i_du_step pulses spaced 4 cycles → pc advances 0→4→8→0xC exactly at pulse edges only.
- Fault: MEM_DEPTH=4, jump to 0x40 → state HALTED, o_fault=1, IF/ID=NOP. cmd 11 → LOAD, pc=RESET_PC, o_fault stays 1 until i_rst.
- Writes outside LOAD ignored: write 0xDEADBEEF @0x0 during RUN → reload and run shows original word. Mid-run i_rst → all outputs at reset values next cycle.
